hamming_rx_deserializer: RTL and testbench
==========================================

# hamming_rx_deserializer

Serial-to-parallel receive stage placed directly upstream of the Hamming (7,4) decoder. It assembles framed serial bits into 7-bit codewords and buffers them in a small FIFO. It then presents each codeword to the decoder through a valid/ready handshake. It also flags framing errors and overflow drops, and keeps a saturating count of dropped codewords.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `serial_in` in 1: received bit.
- `serial_valid` in 1: `serial_in` is sampled this cycle.
- `frame_start` in 1: qualified by `serial_valid`; marks this bit as codeword bit 0.
- `codeword_out` out 7: FIFO head codeword; bit 0 = P1 … bit 6 = D4.
- `codeword_valid` out 1: FIFO non-empty.
- `codeword_ready` in 1: decoder accepts the head this cycle.
- `frame_err` out 1: one-cycle pulse when a partial codeword is aborted.
- `overflow` out 1: one-cycle pulse when a completed codeword is dropped because the FIFO is full.
- `drop_count` out 8: saturating count of overflow drops; holds at 255.

## Operation
- Bit order: LSB first. The first bit received is `codeword[0]`; the 7th bit received is `codeword[6]`.
- FSM states:
  - IDLE: a bit with `serial_valid & frame_start` loads shift bit 0, sets `bit_cnt=1`, and goes to SHIFT. Valid bits without `frame_start` are ignored.
  - SHIFT: each valid bit is stored at position `bit_cnt` and `bit_cnt` increments. When the 7th bit (`bit_cnt==6`) is sampled, the assembled word is pushed and the FSM returns to IDLE.
- `serial_valid` low: state, counter and partial word all hold. There is no timeout.
- Mid-frame `frame_start` (SHIFT, `bit_cnt` 1..6):
  - `frame_err` pulses and the partial word is discarded.
  - The new bit becomes bit 0 of a new codeword, with `bit_cnt=1` and the FSM staying in SHIFT.
- `frame_start` on the 7th bit is treated as a new frame, not as data:
  - `frame_err` pulses and nothing is pushed.
  - The bit becomes bit 0 of a new codeword.
- Push rules:
  - A completed word is pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped, `overflow` pulses and `drop_count` increments (saturating).
- Pop: on `codeword_valid & codeword_ready`. `codeword_ready` while empty has no effect.
- Simultaneous push and pop when empty: the pop is a no-op and the push is accepted.
- FIFO pointers are `$clog2(DEPTH)+1` bits wide and wrap naturally.
  - Full = MSBs differ and the remaining bits are equal.
  - Empty = pointers equal.

## Timing
- Reset values: IDLE, `bit_cnt=0`, FIFO empty, `codeword_out=0`, `codeword_valid=0`, `frame_err=0`, `overflow=0`, `drop_count=0`.
- Reset takes effect immediately, including mid-frame and mid-handshake. The partial word and all FIFO contents are lost.
- Latency: the 7th bit is sampled at edge N. `codeword_valid` rises and `codeword_out` is valid after edge N, i.e. in cycle N+1, provided the FIFO was empty.
- `codeword_out` comes from a registered FIFO head. It is stable while `codeword_valid & !codeword_ready`.
- Throughput: one codeword per 7 valid bits. Back-to-back frames need no idle cycle.
- `frame_err` and `overflow` are registered. They assert in the cycle after the triggering bit and last exactly one cycle.

## Structure
- Package `hamming_pkg` holds:
  - `CODEWORD_W=7`, `DATA_W=4`.
  - The `rx_state_t` enum {IDLE, SHIFT}.
  - The `codeword_t` typedef (`logic [6:0]`), shared with the decoder.
- Sub-module `hamming_fifo`: synchronous FIFO parameterized by `DEPTH` and width.
  - Ports: `push`/`pop`/`full`/`empty`/`dout`.
  - Its reset is the same async active-high `rst`.
- Top level: FSM, shift register, bit counter, drop counter and FIFO instance only.

## Test plan
- **Single frame:** bits 1,0,1,0,1,0,1 with `frame_start` on the first and `codeword_ready=1` → `codeword_out=7'h55` with `codeword_valid` for exactly one cycle, starting the cycle after the 7th bit.
- **Gapped input:** same frame with `serial_valid` low for 3 cycles between bits 3 and 4 → `7'h55` still produced, no `frame_err`.
- **Abort:** `frame_start` at bit 4, then 7 bits 1,1,1,1,1,1,1 → one `frame_err` pulse, then a single output `7'h7F`.
- **Overflow:** `DEPTH=4`, `codeword_ready=0`, 6 frames `7'h01`..`7'h06` → `overflow` pulses twice and `drop_count=2`. Raising ready then yields `7'h01`..`7'h04` in order, then `codeword_valid=0`.
- **Full + simultaneous:** FIFO full and the 7th bit arrives in the same cycle as a pop → no `overflow`, and the FIFO stays full with the new word at the tail.
- **Reset mid-operation:** assert `rst` during bit 3 with 2 words queued → all outputs 0 immediately. After release, a fresh frame `7'h2A` is output normally.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming (7,4) receive path.
// Codeword bit 0 is P1 and bit 6 is D4.
package hamming_pkg;

  localparam int CODEWORD_W = 7;
  localparam int DATA_W     = 4;

  // Index of the final serial bit of a codeword.
  localparam logic [2:0] LAST_BIT = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  typedef logic [CODEWORD_W-1:0] codeword_t;

  // Increment an 8-bit counter, holding at all-ones.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/hamming_fifo.sv
// Synchronous FIFO with a registered head output.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module hamming_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Qualify requests and work out the head value that follows this edge.
  always_comb begin
    rd_en      = pop & ~empty;
    wr_en      = push & (~full | rd_en);
    wr_ptr_nxt = wr_en ? (wr_ptr + PTR_ONE) : wr_ptr;
    rd_ptr_nxt = rd_en ? (rd_ptr + PTR_ONE) : rd_ptr;
    head_nxt   = {WIDTH{1'b0}};
    // When the queue drains to nothing but a word arrives, that word is the new head.
    if (rd_ptr_nxt == wr_ptr) begin
      if (wr_en) begin
        head_nxt = din;
      end else begin
        head_nxt = {WIDTH{1'b0}};
      end
    end else begin
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // Storage array; cleared implicitly by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= PTR_ZERO;
      rd_ptr <= PTR_ZERO;
      dout   <= {WIDTH{1'b0}};
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      dout   <= head_nxt;
    end
  end

endmodule

// File: rtl/hamming_rx_deserializer.sv
// Frames LSB-first serial bits into 7-bit codewords and queues them for the decoder.
// Reports aborted frames, overflow drops and a saturating drop count.
module hamming_rx_deserializer
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            serial_in,
  input  logic            serial_valid,
  input  logic            frame_start,
  output logic [6:0]      codeword_out,
  output logic            codeword_valid,
  input  logic            codeword_ready,
  output logic            frame_err,
  output logic            overflow,
  output logic [7:0]      drop_count
);

  rx_state_t  state;
  logic [2:0] bit_cnt;
  codeword_t  shift;
  codeword_t  word;
  logic       done;
  logic       pop;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;

  assign codeword_valid = ~fifo_empty;

  // Detect frame completion and decide whether the finished word fits.
  always_comb begin
    done = 1'b0;
    word = shift;
    if ((state == SHIFT) && serial_valid && !frame_start && (bit_cnt == LAST_BIT)) begin
      done = 1'b1;
      word = {serial_in, shift[CODEWORD_W-2:0]};
    end else begin
      done = 1'b0;
      word = shift;
    end
    pop  = codeword_valid & codeword_ready;
    // A full FIFO still takes the word if the head leaves on the same edge.
    push = done & (~fifo_full | pop);
  end

  // Framing FSM, shift register, bit counter, status pulses and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shift      <= {CODEWORD_W{1'b0}};
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      if (done && !push) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc8(drop_count);
      end
      if (serial_valid) begin
        case (state)
          IDLE: begin
            if (frame_start) begin
              shift   <= {{(CODEWORD_W-1){1'b0}}, serial_in};
              bit_cnt <= 3'd1;
              state   <= SHIFT;
            end
          end
          SHIFT: begin
            if (frame_start) begin
              // Restart: the partial word is abandoned and this bit opens a new frame.
              frame_err <= 1'b1;
              shift     <= {{(CODEWORD_W-1){1'b0}}, serial_in};
              bit_cnt   <= 3'd1;
            end else if (bit_cnt == LAST_BIT) begin
              shift   <= {CODEWORD_W{1'b0}};
              bit_cnt <= 3'd0;
              state   <= IDLE;
            end else begin
              shift[bit_cnt] <= serial_in;
              bit_cnt        <= bit_cnt + 3'd1;
            end
          end
          default: begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shift   <= {CODEWORD_W{1'b0}};
          end
        endcase
      end
    end
  end

  hamming_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODEWORD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (codeword_out)
  );

endmodule

// File: tb/tb_hamming_rx_deserializer.sv
// Directed bench for hamming_rx_deserializer: inputs change on the falling edge,
// outputs are observed on the following falling edge.
module tb_hamming_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       serial_valid;
  logic       frame_start;
  logic [6:0] codeword_out;
  logic       codeword_valid;
  logic       codeword_ready;
  logic       frame_err;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int err_seen;
  int ovf_seen;
  int valid_cycles;

  always #5 clk = ~clk;

  hamming_rx_deserializer #(.DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .serial_valid   (serial_valid),
    .frame_start    (frame_start),
    .codeword_out   (codeword_out),
    .codeword_valid (codeword_valid),
    .codeword_ready (codeword_ready),
    .frame_err      (frame_err),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  // Present one cycle of serial input, then observe after the rising edge.
  task automatic step(input logic b, input logic fs, input logic v);
    serial_in    = b;
    frame_start  = fs;
    serial_valid = v;
    @(negedge clk);
    serial_in    = 1'b0;
    frame_start  = 1'b0;
    serial_valid = 1'b0;
    if (frame_err) err_seen++;
    if (overflow) ovf_seen++;
    if (codeword_valid) valid_cycles++;
  endtask

  task automatic send_frame(input logic [6:0] w);
    for (int i = 0; i < 7; i++) begin
      step(w[i], (i == 0), 1'b1);
    end
  endtask

  task automatic clear_counts();
    err_seen = 0;
    ovf_seen = 0;
    valid_cycles = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", codeword_valid); end
    checks++; if (codeword_out !== 7'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", codeword_out); end
    checks++; if (frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_pulses: got err=%b ovf=%b expected 0 0", frame_err, overflow); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [6:0] w;
    w = 7'h55;
    codeword_ready = 1'b1;
    clear_counts();
    for (int i = 0; i < 6; i++) step(w[i], (i == 0), 1'b1);
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid=%b expected 0", codeword_valid); end
    step(w[6], 1'b0, 1'b1);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h55) begin errors++; $display("FAIL single_out: got valid=%b out=%h expected 1 55", codeword_valid, codeword_out); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL single_after: got valid=%b expected 0", codeword_valid); end
    checks++; if (valid_cycles != 1 || err_seen != 0) begin errors++; $display("FAIL single_count: got valid_cycles=%0d errs=%0d expected 1 0", valid_cycles, err_seen); end
  endtask

  task automatic test_gapped();
    codeword_ready = 1'b1;
    clear_counts();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h55) begin errors++; $display("FAIL gapped_out: got valid=%b out=%h expected 1 55", codeword_valid, codeword_out); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (err_seen != 0 || valid_cycles != 1) begin errors++; $display("FAIL gapped_count: got errs=%0d valid_cycles=%0d expected 0 1", err_seen, valid_cycles); end
  endtask

  task automatic test_abort();
    codeword_ready = 1'b1;
    clear_counts();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", frame_err); end
    step(1'b1, 1'b0, 1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_width: got %b expected 0", frame_err); end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h7F) begin errors++; $display("FAIL abort_out: got valid=%b out=%h expected 1 7f", codeword_valid, codeword_out); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (err_seen != 1 || valid_cycles != 1) begin errors++; $display("FAIL abort_count: got errs=%0d valid_cycles=%0d expected 1 1", err_seen, valid_cycles); end
  endtask

  task automatic test_back_to_back();
    codeword_ready = 1'b1;
    send_frame(7'h33);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h33) begin errors++; $display("FAIL b2b_first: got valid=%b out=%h expected 1 33", codeword_valid, codeword_out); end
    send_frame(7'h4C);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h4C) begin errors++; $display("FAIL b2b_second: got valid=%b out=%h expected 1 4c", codeword_valid, codeword_out); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b expected 0", codeword_valid); end
  endtask

  task automatic test_overflow();
    codeword_ready = 1'b0;
    clear_counts();
    for (int k = 1; k <= 6; k++) send_frame(7'(k));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b expected 0", overflow); end
    checks++; if (ovf_seen != 2 || drop_count !== 8'd2) begin errors++; $display("FAIL ovf_count: got pulses=%0d drop=%0d expected 2 2", ovf_seen, drop_count); end
    codeword_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'(k)) begin errors++; $display("FAIL ovf_drain: got valid=%b out=%h expected 1 %h", codeword_valid, codeword_out, 7'(k)); end
      @(negedge clk);
    end
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got valid=%b expected 0", codeword_valid); end
    codeword_ready = 1'b0;
  endtask

  task automatic test_full_simultaneous();
    logic [6:0] w;
    codeword_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(7'h11 + 7'(k));
    w = 7'h15;
    for (int i = 0; i < 6; i++) step(w[i], (i == 0), 1'b1);
    codeword_ready = 1'b1;
    step(w[6], 1'b0, 1'b1);
    codeword_ready = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_count !== 8'd2) begin errors++; $display("FAIL simul_no_ovf: got ovf=%b drop=%0d expected 0 2", overflow, drop_count); end
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h12) begin errors++; $display("FAIL simul_head: got valid=%b out=%h expected 1 12", codeword_valid, codeword_out); end
    codeword_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (codeword_valid !== 1'b1 || codeword_out !== (7'h12 + 7'(k))) begin errors++; $display("FAIL simul_drain: got valid=%b out=%h expected 1 %h", codeword_valid, codeword_out, 7'h12 + 7'(k)); end
      @(negedge clk);
    end
    checks++; if (codeword_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got valid=%b expected 0", codeword_valid); end
    codeword_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    codeword_ready = 1'b0;
    send_frame(7'h21);
    send_frame(7'h22);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    serial_in = 1'b1;
    serial_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (codeword_valid !== 1'b0 || codeword_out !== 7'h00) begin errors++; $display("FAIL rstmid_fifo: got valid=%b out=%h expected 0 00", codeword_valid, codeword_out); end
    checks++; if (drop_count !== 8'd0 || frame_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rstmid_status: got drop=%0d err=%b ovf=%b expected 0 0 0", drop_count, frame_err, overflow); end
    @(negedge clk);
    serial_valid = 1'b0;
    serial_in = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    codeword_ready = 1'b1;
    clear_counts();
    send_frame(7'h2A);
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h2A) begin errors++; $display("FAIL rstmid_fresh: got valid=%b out=%h expected 1 2a", codeword_valid, codeword_out); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (codeword_valid !== 1'b0 || err_seen != 0) begin errors++; $display("FAIL rstmid_after: got valid=%b errs=%0d expected 0 0", codeword_valid, err_seen); end
    codeword_ready = 1'b0;
  endtask

  task automatic test_saturation();
    codeword_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_frame(7'h40 + 7'(k));
    for (int k = 0; k < 255; k++) send_frame(7'h0F);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL sat_reach: got %0d expected 255", drop_count); end
    send_frame(7'h0F);
    checks++; if (drop_count !== 8'd255 || overflow !== 1'b1) begin errors++; $display("FAIL sat_hold: got drop=%0d ovf=%b expected 255 1", drop_count, overflow); end
    checks++; if (codeword_valid !== 1'b1 || codeword_out !== 7'h40) begin errors++; $display("FAIL sat_head: got valid=%b out=%h expected 1 40", codeword_valid, codeword_out); end
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b0;
    serial_valid = 1'b0;
    frame_start = 1'b0;
    codeword_ready = 1'b0;
    clear_counts();
    test_reset();
    test_single_frame();
    test_gapped();
    test_abort();
    test_back_to_back();
    test_overflow();
    test_full_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
